// File: rtl/e_frac_to_decimal_pkg.sv
// Shared types and constants for the e-calculation digit converter.
package e_calc_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        EMIT_INT,
        EMIT_DOT,
        MUL,
        EMIT,
        DONE
    } state_t;

    localparam logic [7:0] ZERO      = 8'h30;
    localparam logic [7:0] DOT       = 8'h2E;
    localparam logic [7:0] OVF       = 8'h3F;
    localparam logic [3:0] DIGIT_OVF = 4'hF;

    // Integer word above 9 cannot be shown as a single digit.
    function automatic logic [3:0] int_digit(input logic [WORD_W-1:0] w);
        return (w <= WORD_W'(9)) ? w[3:0] : DIGIT_OVF;
    endfunction

endpackage

// File: rtl/e_frac_to_decimal_if.sv
// Digit stream handshake from the converter toward the UART/display stage.
interface e_frac_to_decimal_if;
    logic       digit_valid;
    logic       digit_ready;
    logic [7:0] digit_out;
    logic       digit_last;

    modport master (
        output digit_valid,
        output digit_out,
        output digit_last,
        input  digit_ready
    );

    modport slave (
        input  digit_valid,
        input  digit_out,
        input  digit_last,
        output digit_ready
    );
endinterface

// File: rtl/e_frac_to_decimal_mul10.sv
// One 16-bit word times ten plus incoming carry; carry out is always <= 9.
module e_mul10_word
    import e_calc_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [3:0]        carry_in,
    output logic [WORD_W-1:0] word_out,
    output logic [3:0]        carry_out
);

    logic [19:0] p;

    assign p         = {4'h0, word} * 20'd10 + {16'h0, carry_in};
    assign word_out  = p[15:0];
    assign carry_out = p[19:16];

endmodule

// File: rtl/e_frac_to_decimal.sv
// Converts a multi-word fixed-point value into a decimal digit stream.
// Build option: E_DIGIT_ASCII_EN selects ASCII characters and a '.' after the integer digit.
module e_frac_to_decimal
    import e_calc_pkg::*;
#(
    parameter int unsigned WORDS   = 32,
    parameter int unsigned NDIGITS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data [0:WORDS-1],
    output logic              busy,
    output logic              done,
    e_frac_to_decimal_if.master dig
);

    localparam int unsigned IDX_W = (WORDS > 2) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
    localparam logic [7:0] CNT_LAST = 8'(NDIGITS - 1);

`ifdef E_DIGIT_ASCII_EN
    localparam state_t AFTER_INT = EMIT_DOT;
`else
    localparam state_t AFTER_INT = MUL;
`endif

    state_t            state, state_nxt;
    logic [WORD_W-1:0] frac [0:WORDS-1];
    logic [3:0]        carry;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        cnt;
    logic [3:0]        int_dig;

    logic [WORD_W-1:0] mul_word;
    logic [3:0]        mul_carry;
    logic              is_last;
    logic [7:0]        int_char;
    logic [7:0]        frac_char;
    logic              valid_c;
    logic              last_c;
    logic [7:0]        char_c;

    // Single multiplier shared across words; idx walks from LSW up to word 1.
    e_mul10_word u_mul10 (
        .word      (frac[idx]),
        .carry_in  (carry),
        .word_out  (mul_word),
        .carry_out (mul_carry)
    );

    assign is_last = (cnt == CNT_LAST);

`ifdef E_DIGIT_ASCII_EN
    assign int_char  = (int_dig == DIGIT_OVF) ? OVF : ZERO + {4'h0, int_dig};
    assign frac_char = ZERO + {4'h0, carry};
`else
    assign int_char  = {4'h0, int_dig};
    assign frac_char = {4'h0, carry};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs decode only registered state, so ready never reaches valid combinationally.
    always_comb begin
        state_nxt = state;
        valid_c   = 1'b0;
        last_c    = 1'b0;
        char_c    = '0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = EMIT_INT;
            end
            EMIT_INT: begin
                valid_c = 1'b1;
                char_c  = int_char;
                if (dig.digit_ready) state_nxt = AFTER_INT;
            end
            EMIT_DOT: begin
                valid_c = 1'b1;
                char_c  = DOT;
                if (dig.digit_ready) state_nxt = MUL;
            end
            MUL: begin
                if (idx == IDX_W'(1)) state_nxt = EMIT;
            end
            EMIT: begin
                valid_c = 1'b1;
                last_c  = is_last;
                char_c  = frac_char;
                if (dig.digit_ready) state_nxt = is_last ? DONE : MUL;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WORDS; i++) frac[i] <= '0;
            carry   <= '0;
            idx     <= '0;
            cnt     <= '0;
            int_dig <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        frac[0] <= '0;
                        for (int unsigned i = 1; i < WORDS; i++) frac[i] <= in_data[i];
                        int_dig <= int_digit(in_data[0]);
                        carry   <= '0;
                        idx     <= '0;
                        cnt     <= '0;
                    end
                end
                EMIT_INT, EMIT_DOT: begin
                    if (dig.digit_ready) begin
                        idx   <= IDX_LAST;
                        carry <= '0;
                    end
                end
                MUL: begin
                    frac[idx] <= mul_word;
                    carry     <= mul_carry;
                    idx       <= idx - IDX_W'(1);
                end
                EMIT: begin
                    if (dig.digit_ready && !is_last) begin
                        cnt   <= cnt + 8'd1;
                        idx   <= IDX_LAST;
                        carry <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dig.digit_valid = valid_c;
    assign dig.digit_last  = last_c;
    assign dig.digit_out   = char_c;
    assign busy            = (state != IDLE) && (state != DONE);
    assign done            = (state == DONE);

endmodule

// File: tb/tb_e_frac_to_decimal.sv
// Table-driven and scoreboard checks of the fixed-point to decimal digit stream.
module tb_e_frac_to_decimal;

    localparam int W  = 4;
    localparam int ND = 8;
`ifdef E_DIGIT_ASCII_EN
    localparam bit ASCII = 1'b1;
`else
    localparam bit ASCII = 1'b0;
`endif
    localparam int NXFER = ND + 1 + (ASCII ? 1 : 0);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] in_data [0:W-1];
    logic        busy;
    logic        done;

    e_frac_to_decimal_if dif ();

    e_frac_to_decimal #(.WORDS(W), .NDIGITS(ND)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .in_data (in_data),
        .busy    (busy),
        .done    (done),
        .dig     (dif.master)
    );

    always #5 clk = ~clk;

    typedef logic [15:0] vec_t [0:W-1];
    typedef logic [3:0]  dig_t [0:ND-1];
    typedef struct {
        vec_t       w;
        logic [3:0] exp_int;
        dig_t       exp_frac;
    } vrec_t;
    typedef struct {
        logic [7:0] ch;
        logic       last;
    } exp_t;

    exp_t        sb [$];
    longint      stamps [$];
    int unsigned checks = 0;
    int unsigned passed = 0;
    longint      cyc = 0;
    int          xfers = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_out = '0;
    logic        prev_last = 1'b0;
    vrec_t       tbl [6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    function automatic logic [7:0] enc_int(input logic [3:0] d);
        if (ASCII) return (d == 4'hF) ? 8'h3F : 8'h30 + {4'h0, d};
        return {4'h0, d};
    endfunction

    function automatic logic [7:0] enc_frac(input logic [3:0] d);
        if (ASCII) return 8'h30 + {4'h0, d};
        return {4'h0, d};
    endfunction

    // Reference: treat words 1..3 as one 48-bit fraction and multiply by ten.
    function automatic dig_t model(input vec_t v);
        dig_t            r;
        longint unsigned f;
        f = {16'h0, v[1], v[2], v[3]};
        for (int k = 0; k < ND; k++) begin
            f    = f * 10;
            r[k] = 4'(f >> 48);
            f    = f & 64'h0000_FFFF_FFFF_FFFF;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", dif.digit_valid, 1);
                check("stall_out", dif.digit_out, prev_out);
                check("stall_last", dif.digit_last, prev_last);
            end
            if (dif.digit_valid && dif.digit_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL extra_digit: got %0h required no transfer", dif.digit_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("digit", dif.digit_out, e.ch);
                    check("last", dif.digit_last, e.last);
                end
                xfers++;
                stamps.push_back(cyc + 1);
            end
            prev_stall = dif.digit_valid && !dif.digit_ready;
            prev_out   = dif.digit_out;
            prev_last  = dif.digit_last;
        end
    end

    task automatic push_expected(input logic [3:0] idig, input dig_t fr);
        exp_t e;
        e.ch = enc_int(idig); e.last = 1'b0; sb.push_back(e);
        if (ASCII) begin
            e.ch = 8'h2E; sb.push_back(e);
        end
        for (int k = 0; k < ND; k++) begin
            e.ch = enc_frac(fr[k]); e.last = (k == ND - 1); sb.push_back(e);
        end
    endtask

    task automatic run(input vec_t v, input logic [3:0] idig, input dig_t fr,
                       input bit rnd, input bit poke, input bit dstart);
        int n;
        push_expected(idig, fr);
        xfers = 0;
        stamps.delete();
        @(posedge clk); #1;
        in_data = v;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", busy, 1);
        check("first_valid_latency", dif.digit_valid, 1);
        for (n = 0; n < 500; n++) begin
            @(posedge clk); #1;
            if (rnd) dif.digit_ready = 1'($urandom_range(0, 1));
            if (poke && (n % 5 == 2)) begin
                start = 1'b1;
                for (int k = 0; k < W; k++) in_data[k] = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) break;
        end
        start = 1'b0;
        if (n == 500) begin
            checks++;
            $display("FAIL timeout: got no done within 500 cycles, required done");
        end else begin
            check("done_after_last", cyc, (stamps.size() > 0) ? stamps[$] : -1);
            check("busy_in_done", busy, 0);
        end
        check("transfers", xfers, NXFER);
        check("scoreboard_drained", sb.size(), 0);
        if (!rnd && stamps.size() == NXFER) begin
            for (int k = 1; k < NXFER; k++)
                check("digit_gap", stamps[k] - stamps[k-1], (ASCII && k == 1) ? 1 : W);
        end
        if (dstart) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dif.digit_ready = 1'b1;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_not_busy", busy, 0);
        check("idle_no_valid", dif.digit_valid, 0);
        sb.delete();
    endtask

    initial begin
        vec_t       v;
        dig_t       d;
        logic [3:0] idig;
        int         n;

        tbl[0].w = '{16'd1, 16'h8000, 16'h0000, 16'h0000};
        tbl[0].exp_int = 4'd1;  tbl[0].exp_frac = '{5, 0, 0, 0, 0, 0, 0, 0};
        tbl[1].w = '{16'd0, 16'h1000, 16'h0000, 16'h0000};
        tbl[1].exp_int = 4'd0;  tbl[1].exp_frac = '{0, 6, 2, 5, 0, 0, 0, 0};
        tbl[2].w = '{16'd2, 16'hB7E1, 16'h5162, 16'h8AED};
        tbl[2].exp_int = 4'd2;  tbl[2].exp_frac = '{7, 1, 8, 2, 8, 1, 8, 2};
        tbl[3].w = '{16'd12, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        tbl[3].exp_int = 4'hF;  tbl[3].exp_frac = '{9, 9, 9, 9, 9, 9, 9, 9};
        tbl[4].w = '{16'd9, 16'h0000, 16'h0000, 16'h0001};
        tbl[4].exp_int = 4'd9;  tbl[4].exp_frac = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[5].w = '{16'd10, 16'h4000, 16'h0000, 16'h0000};
        tbl[5].exp_int = 4'hF;  tbl[5].exp_frac = '{2, 5, 0, 0, 0, 0, 0, 0};

        for (int k = 0; k < W; k++) in_data[k] = '0;
        dif.digit_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_valid", dif.digit_valid, 0);
        check("reset_last", dif.digit_last, 0);
        check("reset_out", dif.digit_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run(tbl[i].w, tbl[i].exp_int, tbl[i].exp_frac, 1'b0, 1'b0, 1'b0);

        // Backpressure plus start pulses and in_data churn while busy.
        run(tbl[2].w, tbl[2].exp_int, tbl[2].exp_frac, 1'b1, 1'b1, 1'b0);
        // Start during DONE must not launch a new conversion.
        run(tbl[0].w, tbl[0].exp_int, tbl[0].exp_frac, 1'b0, 1'b0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            v[0] = 16'($urandom_range(0, 12));
            for (int k = 1; k < W; k++) v[k] = 16'($urandom);
            idig = (v[0] <= 9) ? v[0][3:0] : 4'hF;
            run(v, idig, model(v), 1'b1, 1'b0, 1'b0);
        end

        // Abort mid-MUL, then a fresh full conversion.
        push_expected(tbl[2].exp_int, tbl[2].exp_frac);
        xfers = 0;
        @(posedge clk); #1;
        in_data = tbl[2].w;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (n = 0; n < 50 && xfers < 2; n++) @(negedge clk);
        check("reached_mul", xfers, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", dif.digit_valid, 0);
        check("abort_out", dif.digit_out, 0);
        check("abort_last", dif.digit_last, 0);
        check("abort_done", done, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(tbl[2].w, tbl[2].exp_int, tbl[2].exp_frac, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/e_frac_to_decimal.md
Name: e_frac_to_decimal

Overview:
- Downstream stage of the e-calculation squaring stage.
- Takes its final multi-word fixed-point result and converts it to a stream of decimal digits, integer digit first, then NDIGITS fractional digits.
- Each fractional digit comes from multiplying the fraction by 10, word-serially, and taking the carry out of the top fraction word.
- Digits leave on a valid/ready handshake toward a UART/display stage.

Parameters:
- WORDS, 32, number of 16-bit words in the fixed-point value; word 0 = integer part, word 1 = most significant fraction word, word WORDS-1 = least significant.
- NDIGITS, 16, number of fractional digits emitted after the integer digit (1..255).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  load in_data and begin conversion; sampled only in IDLE.
- in_data  input  16 x WORDS (unpacked [0:WORDS-1])  fixed-point value; the upstream out_data array.
- busy  output  1  high from the cycle after start is accepted until done.
- digit_valid  output  1  digit_out holds a valid character.
- digit_ready  input  1  consumer accepts; transfer when digit_valid and digit_ready are both high.
- digit_out  output  8  character; BCD in bits [3:0] with [7:4]=0, or ASCII with E_DIGIT_ASCII_EN.
- digit_last  output  1  high with the final fractional digit.
- done  output  1  one-cycle pulse after the last transfer.

Behaviour:
- Reset values:
  - busy, digit_valid, digit_last, done = 0; digit_out = 0.
  - Internal word register, carry, word index and digit counter = 0; state = IDLE.
  - Reset mid-operation aborts immediately; no partial digits are retained.
- IDLE:
  - start=1 latches words 1..WORDS-1 into the internal fraction register.
  - Integer digit = in_data[0][3:0] if in_data[0] <= 9, else 4'hF (overflow marker).
  - Next state EMIT_INT; busy=1 next cycle.
- EMIT_INT: digit_valid=1 with the integer digit. On transfer go to MUL (or EMIT_DOT with the macro). Index = WORDS-1, carry = 0.
- MUL: one word per cycle, least significant word first.
  - p = word[idx]*10 + carry, 20 bits.
  - word[idx] <= p[15:0]; carry <= p[19:16], always <= 9.
  - After idx=1 is processed, the final carry is the digit; go to EMIT.
  - Costs WORDS-1 cycles per digit.
- EMIT:
  - digit_valid=1 and digit_out = carry.
  - digit_last=1 when the digit counter = NDIGITS-1.
  - On transfer: if last, go to DONE; else counter+1, idx = WORDS-1, carry = 0, back to MUL.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- Backpressure:
  - While digit_valid=1 and digit_ready=0, digit_out and digit_last stay stable and valid stays high.
  - digit_valid drops the cycle after a transfer; no combinational ready-to-valid path.
- start while busy is ignored. start in the same cycle as DONE is ignored; it is accepted from IDLE one cycle later.
- in_data is only sampled at start; upstream may change it during conversion.
- Exactness: the ×10 is done in full precision on the stored words, so digits are the exact truncated decimal expansion of the stored fraction.
- Latency from start to first valid = 1 cycle. Each fractional digit follows its predecessor's transfer by WORDS-1 cycles, +1 for the EMIT state.

Optional Feature:
- Macro: E_DIGIT_ASCII_EN.
- Defined:
  - digit_out = 8'h30 + digit; overflow marker = 8'h3F ('?').
  - State EMIT_DOT emits 8'h2E ('.') after the integer digit. Total transfers = NDIGITS+2.
- Undefined: BCD output, no dot state. Total transfers = NDIGITS+1.

Decomposition:
- Package e_calc_pkg:
  - WORD_W=16.
  - State enum: IDLE, EMIT_INT, EMIT_DOT, MUL, EMIT, DONE.
  - ASCII constants: ZERO=8'h30, DOT=8'h2E, OVF=8'h3F.
  - DIGIT_OVF=4'hF.
- Sub-module e_mul10_word: combinational, in word[15:0] + carry_in[3:0] -> word_out[15:0] + carry_out[3:0]. Instanced once and time-multiplexed by idx.

Test Plan:
- WORDS=4, in_data={1,16'h8000,0,0}, NDIGITS=4, ready tied 1 -> digits 1,5,0,0,0; digit_last on the 5th transfer; done one cycle later.
- WORDS=4, in_data={0,16'h1000,0,0}, NDIGITS=5 -> 0,0,6,2,5,0.
- WORDS=4, in_data={2,16'hB7E1,16'h5162,16'h8AED}, NDIGITS=8 -> 2,7,1,8,2,8,1,8,2, matching a reference-model truncation of the loaded value.
- Random digit_ready toggling on the e vector -> identical digit sequence; digit_out stable whenever valid&&!ready; start pulses while busy have no effect.
- Assert rst_n low mid-MUL -> all outputs 0 next edge. A fresh start after release gives a correct full sequence.
- With E_DIGIT_ASCII_EN, e vector -> 8'h32,8'h2E,8'h37,8'h31,... In a separate run, in_data[0]=12 -> first character 8'h3F.
